reg_bus_arbiter: RTL and testbench

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

---
 rtl/reg_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_reg_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter granting four requesters single-cycle access to a 4-register bank.
// Optional REG_ARB_LOCK_EN adds req_lock for back-to-back transfers by the current winner.
module reg_bus_arbiter #(
    parameter int    UUID   = 0,
    parameter string NAME   = "",
    parameter int    DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [3:0]            req_we,
    input  logic [7:0]            req_addr,
    input  logic [4*DATA_W-1:0]   req_wdata,
`ifdef REG_ARB_LOCK_EN
    input  logic [3:0]            req_lock,
`endif
    output logic [3:0]            gnt,
    output logic [3:0]            done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic [3:0]            reg_rd_en,
    output logic [3:0]            reg_wr_en,
    output logic [DATA_W-1:0]     reg_wdata,
    input  logic [DATA_W-1:0]     reg_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [1:0]          ptr;
    logic [1:0]          win;
    logic                l_we;
    logic [1:0]          l_addr;
    logic [DATA_W-1:0]   l_wdata;

    logic [1:0]          arb_idx;
    logic [1:0]          load_idx;
    logic                load;
    logic                capture;
    logic                ptr_upd;

    // First requester found scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
    always_comb begin
        arb_idx = ptr;
        for (int unsigned i = 4; i >= 1; i--) begin
            logic [1:0] idx;
            idx = ptr + 2'(i);
            if (req[idx]) arb_idx = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        done      = '0;
        reg_rd_en = '0;
        reg_wr_en = '0;
        reg_wdata = '0;
        load      = 1'b0;
        load_idx  = arb_idx;
        capture   = 1'b0;
        ptr_upd   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (|req) begin
                    load      = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                gnt[win] = 1'b1;
                if (l_we) begin
                    reg_wr_en[l_addr] = 1'b1;
                    reg_wdata         = l_wdata;
                end else begin
                    reg_rd_en[l_addr] = 1'b1;
                    capture           = 1'b1;
                end
                state_nxt = RESP;
            end
            RESP: begin
                done[win] = 1'b1;
`ifdef REG_ARB_LOCK_EN
                if (req[win] && req_lock[win]) begin
                    load      = 1'b1;
                    load_idx  = win;
                    state_nxt = XFER;
                end else begin
                    ptr_upd   = 1'b1;
                    state_nxt = IDLE;
                end
`else
                ptr_upd   = 1'b1;
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= 2'd3;
            win     <= '0;
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
            rdata   <= '0;
        end else begin
            if (load) begin
                win     <= load_idx;
                l_we    <= req_we[load_idx];
                l_addr  <= req_addr[2*int'(load_idx) +: 2];
                l_wdata <= req_wdata[DATA_W*int'(load_idx) +: DATA_W];
            end
            if (capture) rdata <= reg_rdata;
            if (ptr_upd) ptr   <= win;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed self-checking bench for reg_bus_arbiter; lock scenario runs when REG_ARB_LOCK_EN is defined.
module tb_reg_bus_arbiter;

    localparam int DATA_W = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [3:0]          req = '0;
    logic [3:0]          req_we = '0;
    logic [7:0]          req_addr = '0;
    logic [4*DATA_W-1:0] req_wdata = '0;
`ifdef REG_ARB_LOCK_EN
    logic [3:0]          req_lock = '0;
`endif
    logic [3:0]          gnt;
    logic [3:0]          done;
    logic [DATA_W-1:0]   rdata;
    logic                busy;
    logic [3:0]          reg_rd_en;
    logic [3:0]          reg_wr_en;
    logic [DATA_W-1:0]   reg_wdata;
    logic [DATA_W-1:0]   reg_rdata = '0;

    int total = 0;
    int bad   = 0;

    reg_bus_arbiter #(.UUID(1), .NAME("tb_arb"), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef REG_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .reg_rd_en (reg_rd_en),
        .reg_wr_en (reg_wr_en),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #4;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({gnt, done, reg_rd_en, reg_wr_en, busy} !== 17'd0) begin
            bad++;
            $display("FAIL reset_ctrl got=%h want=0", {gnt, done, reg_rd_en, reg_wr_en, busy});
        end
        total++;
        if ({rdata, reg_wdata} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_data got=%h want=0000", {rdata, reg_wdata});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        req = 4'b0001; req_we = 4'b0001; req_addr = 8'h02; req_wdata = 32'h000000A5;
        step();
        req = 4'b0000; req_addr = 8'h00; req_wdata = 32'h0;
        total++;
        if ({gnt, reg_wr_en, reg_rd_en, busy} !== 13'b0001_0100_0000_1) begin
            bad++;
            $display("FAIL wr_xfer got gnt=%b wr=%b rd=%b busy=%b want 0001 0100 0000 1", gnt, reg_wr_en, reg_rd_en, busy);
        end
        total++;
        if (reg_wdata !== 8'hA5) begin
            bad++;
            $display("FAIL wr_data got=%h want=a5", reg_wdata);
        end
        step();
        total++;
        if ({done, gnt, reg_wr_en, rdata} !== {4'b0001, 4'b0000, 4'b0000, 8'h00}) begin
            bad++;
            $display("FAIL wr_resp got done=%b gnt=%b wr=%b rdata=%h want 0001 0000 0000 00", done, gnt, reg_wr_en, rdata);
        end
        step();
        total++;
        if ({done, busy} !== 5'b0000_0) begin
            bad++;
            $display("FAIL wr_idle got done=%b busy=%b want 0000 0", done, busy);
        end
        req = 4'b0001; req_we = 4'b0000; req_addr = 8'h02;
        step();
        req = 4'b0000;
        reg_rdata = 8'hA5;
        total++;
        if ({gnt, reg_rd_en, reg_wr_en} !== 12'b0001_0100_0000) begin
            bad++;
            $display("FAIL rd_xfer got gnt=%b rd=%b wr=%b want 0001 0100 0000", gnt, reg_rd_en, reg_wr_en);
        end
        step();
        reg_rdata = 8'h00;
        total++;
        if ({done, rdata} !== {4'b0001, 8'hA5}) begin
            bad++;
            $display("FAIL rd_resp got done=%b rdata=%h want 0001 a5", done, rdata);
        end
        step();
        total++;
        if ({done, rdata} !== {4'b0000, 8'hA5}) begin
            bad++;
            $display("FAIL rd_hold got done=%b rdata=%h want 0000 a5", done, rdata);
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_g;
        req = 4'b1111; req_we = 4'b0000; req_addr = 8'h00;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            step();
            total++;
            if ({gnt, reg_rd_en, reg_wr_en, done} !== {exp_g, 4'b0001, 4'b0000, 4'b0000}) begin
                bad++;
                $display("FAIL cont_xfer%0d got gnt=%b rd=%b wr=%b done=%b want gnt=%b rd=0001", k, gnt, reg_rd_en, reg_wr_en, done, exp_g);
            end
            step();
            total++;
            if ({done, gnt} !== {exp_g, 4'b0000}) begin
                bad++;
                $display("FAIL cont_resp%0d got done=%b gnt=%b want %b 0000", k, done, gnt, exp_g);
            end
            step();
            total++;
            if ({done, busy} !== 5'b0000_0) begin
                bad++;
                $display("FAIL cont_idle%0d got done=%b busy=%b want 0000 0", k, done, busy);
            end
            if (k == 4) req = 4'b0000;
        end
    endtask

    task automatic test_ptr_skip();
        logic [3:0] exp_g [3] = '{4'b0010, 4'b0001, 4'b0010};
        logic [3:0] req_v [3] = '{4'b0010, 4'b0011, 4'b0011};
        for (int k = 0; k < 3; k++) begin
            req = req_v[k];
            step();
            total++;
            if (gnt !== exp_g[k]) begin
                bad++;
                $display("FAIL skip_gnt%0d got=%b want=%b", k, gnt, exp_g[k]);
            end
            step();
            step();
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_xfer();
        req = 4'b0100;
        step();
        total++;
        if (reg_rd_en !== 4'b0001) begin
            bad++;
            $display("FAIL mid_pre got rd=%b want 0001", reg_rd_en);
        end
        req = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({gnt, reg_rd_en, reg_wr_en, busy} !== 13'd0) begin
            bad++;
            $display("FAIL mid_abort got gnt=%b rd=%b wr=%b busy=%b want all 0", gnt, reg_rd_en, reg_wr_en, busy);
        end
        step();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            total++;
            if ({done, busy} !== 5'd0) begin
                bad++;
                $display("FAIL mid_nodone%0d got done=%b busy=%b want 0000 0", k, done, busy);
            end
        end
        req = 4'b0101;
        step();
        req = 4'b0000;
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL mid_next got gnt=%b want 0001", gnt);
        end
        step();
        step();
    endtask

`ifdef REG_ARB_LOCK_EN
    task automatic test_lock();
        req = 4'b0110; req_lock = 4'b0010; req_we = 4'b0000; req_addr = 8'h00;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (gnt !== 4'b0010) begin
                bad++;
                $display("FAIL lock_gnt%0d got=%b want=0010", k, gnt);
            end
            if (k == 2) req_lock = 4'b0000;
            step();
            total++;
            if (done !== 4'b0010) begin
                bad++;
                $display("FAIL lock_done%0d got=%b want=0010", k, done);
            end
        end
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL lock_idle got busy=%b want 0", busy);
        end
        step();
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL lock_next got gnt=%b want 0100", gnt);
        end
        req = 4'b0000;
        step();
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_ptr_skip();
        test_reset_mid_xfer();
`ifdef REG_ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
